button_event_decoder: RTL and testbench

- Consumes the debounced switch level from the debouncer stage, one clock domain, and classifies it into single-cycle event pulses: press, release, short press, long press and double click.
- Feeds downstream control logic such as counters, mode FSMs and LED drivers, which act on clean one-cycle strobes instead of raw levels.
- Input is already synchronous and bounce-free; this block does no filtering.

---
 rtl/button_event_decoder.sv | 153 +++++++++++++++
 tb/tb_button_event_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/double-click strobes.
// Optional auto-repeat strobes in the long-hold state are built when BTN_REPEAT_EN is defined.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 16,
    parameter int DCLICK_WINDOW = 8,
    parameter int CNT_W         = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic db_in,
    output logic press_p,
    output logic release_p,
    output logic short_p,
    output logic long_p,
    output logic dclick_p,
    output logic repeat_p
);

    generate
        if (LONG_CYCLES < 2 || DCLICK_WINDOW < 2 || REPEAT_CYCLES < 1 ||
            LONG_CYCLES > (2**CNT_W - 1) || DCLICK_WINDOW > (2**CNT_W - 1) ||
            REPEAT_CYCLES > (2**CNT_W - 1)) begin : g_bad_param
            $error("button_event_decoder: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             prev;
    logic             rise, fall;
    logic             short_nx, long_nx, dclick_nx;

    assign rise    = db_in & ~prev;
    assign fall    = ~db_in & prev;
    // Saturating increment: the counter must never wrap back to a small value.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        dclick_nx = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESS1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            PRESS1, PRESS2: begin
                if (db_in) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == CNT_W'(LONG_CYCLES)) begin
                        state_nx = LONG;
                        long_nx  = 1'b1;
                    end
                end else if (state == PRESS1) begin
                    state_nx = WAIT2;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    dclick_nx = 1'b1;
                end
            end
            LONG: begin
                if (!db_in) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            WAIT2: begin
                // A rise wins over window expiry; expiry can only happen on a low sample.
                if (db_in) begin
                    state_nx = PRESS2;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == CNT_W'(DCLICK_WINDOW)) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        short_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            short_p   <= 1'b0;
            long_p    <= 1'b0;
            dclick_p  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            prev      <= db_in;
            press_p   <= rise;
            release_p <= fall;
            short_p   <= short_nx;
            long_p    <= long_nx;
            dclick_p  <= dclick_nx;
        end
    end

`ifdef BTN_REPEAT_EN
    logic [CNT_W-1:0] rcnt, rcnt_nx, rcnt_inc;
    logic             repeat_nx;

    assign rcnt_inc = (rcnt == {CNT_W{1'b1}}) ? rcnt : rcnt + 1'b1;

    always_comb begin
        rcnt_nx   = rcnt;
        repeat_nx = 1'b0;
        if (long_nx) begin
            rcnt_nx = '0;
        end else if (state == LONG && db_in) begin
            if (rcnt_inc == CNT_W'(REPEAT_CYCLES)) begin
                rcnt_nx   = '0;
                repeat_nx = 1'b1;
            end else begin
                rcnt_nx = rcnt_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rcnt     <= '0;
            repeat_p <= 1'b0;
        end else begin
            rcnt     <= rcnt_nx;
            repeat_p <= repeat_nx;
        end
    end
`else
    assign repeat_p = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder against a run-length reference model.
module tb_button_event_decoder;

    localparam int LONG   = 8;
    localparam int DCLICK = 6;
    localparam int REP    = 4;

    logic clock = 1'b0;
    logic reset;
    logic db_in;
    logic press_p, release_p, short_p, long_p, dclick_p, repeat_p;

    int passed = 0;
    int total  = 0;

    // Reference state: lengths of the current high/low runs plus gesture flags.
    bit m_prev;
    int hi_len, lo_len;
    bit pending, second;

    button_event_decoder #(
        .LONG_CYCLES  (LONG),
        .DCLICK_WINDOW(DCLICK),
        .CNT_W        (8),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .db_in    (db_in),
        .press_p  (press_p),
        .release_p(release_p),
        .short_p  (short_p),
        .long_p   (long_p),
        .dclick_p (dclick_p),
        .repeat_p (repeat_p)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] outs();
        return {press_p, release_p, short_p, long_p, dclick_p, repeat_p};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s t=%0t observed=%b expected=%b (press,rel,short,long,dclick,rep)",
                    tag, $time, obs, exp);
    endtask

    task automatic model_reset();
        m_prev = 0; hi_len = 0; lo_len = 0; pending = 0; second = 0;
    endtask

    // One sample: drive, clock, then compare against the model's prediction.
    task automatic step(input bit b, input string tag);
        bit e_press, e_rel, e_short, e_long, e_dclick, e_rep;
        bit rise, fall;
        e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_dclick = 0; e_rep = 0;
        db_in = b;
        @(posedge clock);
        #1;
        rise = b && !m_prev;
        fall = !b && m_prev;
        e_press = rise;
        e_rel   = fall;
        if (b) begin
            if (rise) begin
                hi_len  = 1;
                second  = pending;
                pending = 0;
            end else begin
                hi_len++;
            end
            if (hi_len == LONG) begin
                e_long = 1;
                second = 0;
            end
`ifdef BTN_REPEAT_EN
            e_rep = (hi_len > LONG) && ((hi_len - LONG) % REP == 0);
`endif
        end else begin
            if (fall) begin
                if (hi_len < LONG) begin
                    if (second) e_dclick = 1;
                    else        pending  = 1;
                end
                second = 0;
                lo_len = 1;
            end else begin
                lo_len++;
            end
            if (pending && lo_len == DCLICK) begin
                e_short = 1;
                pending = 0;
            end
        end
        m_prev = b;
        check(tag, outs(), {e_press, e_rel, e_short, e_long, e_dclick, e_rep});
    endtask

    task automatic run(input bit b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    initial begin
        reset = 1'b1;
        db_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", outs(), 6'b0);
        reset = 1'b0;

        run(0, 2, "idle");
        run(1, 3, "short_hi");   run(0, 10, "short_lo");
        run(1, 12, "long_hi");   run(0, 4, "long_lo");
        run(1, 2, "dc_hi1");     run(0, 3, "dc_lo1");
        run(1, 2, "dc_hi2");     run(0, 10, "dc_lo2");
        run(1, 2, "late_hi1");   run(0, 7, "late_lo1");
        run(1, 2, "late_hi2");   run(0, 10, "late_lo2");
        // Second press arriving on the last sample before expiry still counts.
        run(1, 1, "edge_hi1");   run(0, DCLICK - 1, "edge_lo1");
        run(1, 1, "edge_hi2");   run(0, 8, "edge_lo2");
        // Second press held long abandons the double click.
        run(1, 2, "dl_hi1");     run(0, 2, "dl_lo1");
        run(1, 10, "dl_hi2");    run(0, 8, "dl_lo2");

        // Reset mid-hold, released with the button still down.
        run(1, 6, "rst_hold");
        reset = 1'b1;
        #2;
        check("reset_async", outs(), 6'b0);
        @(posedge clock);
        #1;
        check("reset_held", outs(), 6'b0);
        model_reset();
        reset = 1'b0;
        run(1, 10, "post_rst_hi"); run(0, 8, "post_rst_lo");

        run(1, 20, "repeat_hi");  run(0, 6, "repeat_lo");

        for (int k = 0; k < 60; k++) begin
            run(1, $urandom_range(1, 12), "rand_hi");
            run(0, $urandom_range(1, 9), "rand_lo");
        end
        run(0, 10, "tail");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
